// File: rtl/add_multiplex_shift.sv
// ============================================================================
// Module   : add_multiplex_shift
// Purpose  : LUT5 fabric configurable as 2-bit adder, 8:1 mux or 8-bit shifter.
//            Optional macro ADD_MUX_SHIFT_CFG_READBACK_EN adds cfg_rdata.
// Revision : 1.0
// ============================================================================
`default_nettype none

module add_multiplex_shift_cell (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] i_lut,
    input  logic        i_mode,
    input  logic [4:0]  i_a,
    output logic        o_y
);
    logic w_comb;
    logic r_q;

    assign w_comb = i_lut[i_a];

    always_ff @(posedge clock) begin
        if (!reset_n) r_q <= 1'b0;
        else          r_q <= w_comb;
    end

    assign o_y = i_mode ? r_q : w_comb;
endmodule

module add_multiplex_shift (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [11:0] in,
    output logic [8:0]  out,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
`ifdef ADD_MUX_SHIFT_CFG_READBACK_EN
    output logic [31:0] cfg_rdata,
`endif
    input  logic [31:0] cfg_data
);
    localparam int c_ADD0 = 0;
    localparam int c_ADD1 = 1;
    localparam int c_ADDC = 2;
    localparam int c_MUX  = 3;
    localparam int c_MUXS = 4;
    localparam int c_REGC = 5;

    // Configuration has a power-up value only; reset_n never touches it.
    logic [31:0] r_lut [0:5] = '{default: 32'h0};
    logic [5:0]  r_mode      = 6'h0;
    logic [15:0] r_sb0       = 16'h0;
    logic [15:0] r_sb12      = 16'h0;
    logic [15:0] r_sb3       = 16'h0;

    always_ff @(posedge clock) begin
        if (cfg_we) begin
            if (cfg_addr < 4'd12) begin
                if (cfg_addr[0]) r_mode[cfg_addr[3:1]] <= cfg_data[0];
                else             r_lut[cfg_addr[3:1]]  <= cfg_data;
            end else begin
                case (cfg_addr)
                    4'd12:   r_sb0  <= cfg_data[15:0];
                    4'd13:   r_sb12 <= cfg_data[15:0];
                    4'd14:   r_sb3  <= cfg_data[15:0];
                    default: ;
                endcase
            end
        end
    end

    logic w_unused_sb;
    assign w_unused_sb = ^{r_sb0[15:1], r_sb12[15:1], r_sb3[15:2]};

    // Adder group
    logic [1:0] w_a, w_b;
    logic       w_c0, w_c1, w_c2, w_p0, w_p1, w_s0, w_s1;
    assign w_a  = in[1:0] & {2{r_sb0[0]}};
    assign w_b  = in[3:2] & {2{r_sb0[0]}};
    assign w_c0 = in[4] & r_sb0[0];

    add_multiplex_shift_cell u_add1_0 (.clock(clock), .reset_n(reset_n), .i_lut(r_lut[c_ADD1]),
        .i_mode(r_mode[c_ADD1]), .i_a({3'b0, w_b[0], w_a[0]}), .o_y(w_p0));
    add_multiplex_shift_cell u_add1_1 (.clock(clock), .reset_n(reset_n), .i_lut(r_lut[c_ADD1]),
        .i_mode(r_mode[c_ADD1]), .i_a({3'b0, w_b[1], w_a[1]}), .o_y(w_p1));
    add_multiplex_shift_cell u_addc_0 (.clock(clock), .reset_n(reset_n), .i_lut(r_lut[c_ADDC]),
        .i_mode(r_mode[c_ADDC]), .i_a({2'b0, w_a[0], w_b[0], w_c0}), .o_y(w_c1));
    add_multiplex_shift_cell u_addc_1 (.clock(clock), .reset_n(reset_n), .i_lut(r_lut[c_ADDC]),
        .i_mode(r_mode[c_ADDC]), .i_a({2'b0, w_a[1], w_b[1], w_c1}), .o_y(w_c2));
    add_multiplex_shift_cell u_add0_0 (.clock(clock), .reset_n(reset_n), .i_lut(r_lut[c_ADD0]),
        .i_mode(r_mode[c_ADD0]), .i_a({3'b0, w_p0, w_c0}), .o_y(w_s0));
    add_multiplex_shift_cell u_add0_1 (.clock(clock), .reset_n(reset_n), .i_lut(r_lut[c_ADD0]),
        .i_mode(r_mode[c_ADD0]), .i_a({3'b0, w_p1, w_c1}), .o_y(w_s1));

    // Select routing shared by the mux tree and the shift trees
    logic w_s8, w_s9, w_s10;
    assign w_s8  = in[8]  & r_sb12[0];
    assign w_s9  = in[9]  & r_sb12[0];
    assign w_s10 = in[10] & r_sb12[0];

    logic [3:0] w_l1;
    logic [1:0] w_l2;
    logic       w_root;

    for (genvar j = 0; j < 4; j++) begin : g_mux_l1
        add_multiplex_shift_cell u_cell (.clock(clock), .reset_n(reset_n), .i_lut(r_lut[c_MUX]),
            .i_mode(r_mode[c_MUX]), .i_a({2'b0, w_s8, in[2*j+1], in[2*j]}), .o_y(w_l1[j]));
    end

    for (genvar j = 0; j < 2; j++) begin : g_mux_l2
        add_multiplex_shift_cell u_cell (.clock(clock), .reset_n(reset_n), .i_lut(r_lut[c_MUX]),
            .i_mode(r_mode[c_MUX]), .i_a({2'b0, w_s9, w_l1[2*j+1], w_l1[2*j]}), .o_y(w_l2[j]));
    end

    add_multiplex_shift_cell u_mux_root (.clock(clock), .reset_n(reset_n), .i_lut(r_lut[c_MUX]),
        .i_mode(r_mode[c_MUX]), .i_a({2'b0, w_s10, w_l2[1], w_l2[0]}), .o_y(w_root));

    // Shift group; neighbours feed from the MUXS flops so a mis-set mode never closes a loop
    logic       w_regc1, w_regc2;
    logic [7:0] w_r1, w_r2, w_muxs_comb, w_q;
    logic [7:0] r_shq;
    logic [9:0] w_qx;

    add_multiplex_shift_cell u_regc_1 (.clock(clock), .reset_n(reset_n), .i_lut(r_lut[c_REGC]),
        .i_mode(r_mode[c_REGC]), .i_a({4'b0, in[11]}), .o_y(w_regc1));
    add_multiplex_shift_cell u_regc_2 (.clock(clock), .reset_n(reset_n), .i_lut(r_lut[c_REGC]),
        .i_mode(r_mode[c_REGC]), .i_a({4'b0, in[11]}), .o_y(w_regc2));

    assign w_qx = {w_regc2, r_shq, w_regc1};

    for (genvar k = 0; k < 8; k++) begin : g_shift
        add_multiplex_shift_cell u_r1 (.clock(clock), .reset_n(reset_n), .i_lut(r_lut[c_MUX]),
            .i_mode(r_mode[c_MUX]), .i_a({2'b0, w_s8, in[k], r_shq[k]}), .o_y(w_r1[k]));
        add_multiplex_shift_cell u_r2 (.clock(clock), .reset_n(reset_n), .i_lut(r_lut[c_MUX]),
            .i_mode(r_mode[c_MUX]), .i_a({2'b0, w_s9, w_qx[k+2], w_qx[k]}), .o_y(w_r2[k]));
        assign w_muxs_comb[k] = r_lut[c_MUXS][{2'b0, w_s10, w_r2[k], w_r1[k]}];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) r_shq <= 8'h00;
        else          r_shq <= w_muxs_comb;
    end

    assign w_q = r_mode[c_MUXS] ? r_shq : w_muxs_comb;

    always_comb begin
        out = 9'h000;
        case (r_sb3[1:0])
            2'd0:    out[2:0] = {w_c2, w_s1, w_s0};
            2'd1:    out[0]   = w_root;
            2'd2:    out      = {w_regc2, w_q};
            default: ;
        endcase
    end

`ifdef ADD_MUX_SHIFT_CFG_READBACK_EN
    always_comb begin
        cfg_rdata = 32'h0;
        if (cfg_addr < 4'd12) begin
            if (cfg_addr[0]) cfg_rdata = {31'h0, r_mode[cfg_addr[3:1]]};
            else             cfg_rdata = r_lut[cfg_addr[3:1]];
        end else begin
            case (cfg_addr)
                4'd12:   cfg_rdata = {16'h0, r_sb0};
                4'd13:   cfg_rdata = {16'h0, r_sb12};
                4'd14:   cfg_rdata = {16'h0, r_sb3};
                default: cfg_rdata = 32'h0;
            endcase
        end
    end
`endif
endmodule

`default_nettype wire

// File: tb/tb_add_multiplex_shift.sv
// ============================================================================
// Module   : tb_add_multiplex_shift
// Purpose  : Directed and randomized self-checking bench for add_multiplex_shift.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_add_multiplex_shift;
    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [11:0] in = 12'h000;
    logic [8:0]  out;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = 4'h0;
    logic [31:0] cfg_data = 32'h0;
    logic [31:0] rdata;

    add_multiplex_shift dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in       (in),
        .out      (out),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
`ifdef ADD_MUX_SHIFT_CFG_READBACK_EN
        .cfg_rdata(rdata),
`endif
        .cfg_data (cfg_data)
    );

`ifndef ADD_MUX_SHIFT_CFG_READBACK_EN
    assign rdata = 32'h0;
`endif

    always #5 clock = ~clock;

    // Behavioural model: switch-box state and the 8-bit shift register value
    logic       m_sb0  = 1'b0;
    logic       m_sb12 = 1'b0;
    logic [1:0] m_sb3  = 2'd0;
    logic [7:0] m_q    = 8'h00;

    function automatic logic [7:0] q_next(input logic [11:0] x, input logic [7:0] q, input logic en);
        logic s8, s9, s10;
        s8 = x[8] & en; s9 = x[9] & en; s10 = x[10] & en;
        if (s10) return s9 ? {x[11], q[7:1]} : {q[6:0], x[11]};
        return s8 ? x[7:0] : q;
    endfunction

    function automatic logic [8:0] model_out(input logic [11:0] x);
        int a, b, c, sel;
        a = m_sb0 ? int'(x[1:0]) : 0;
        b = m_sb0 ? int'(x[3:2]) : 0;
        c = m_sb0 ? int'(x[4])   : 0;
        sel = m_sb12 ? int'(x[10:8]) : 0;
        case (m_sb3)
            2'd0:    return 9'(a + b + c);
            2'd1:    return {8'h00, x[sel]};
            2'd2:    return {x[11], m_q};
            default: return 9'h000;
        endcase
    endfunction

    always @(posedge clock) begin
        if (cfg_we) begin
            case (cfg_addr)
                4'd12:   m_sb0  <= cfg_data[0];
                4'd13:   m_sb12 <= cfg_data[0];
                4'd14:   m_sb3  <= cfg_data[1:0];
                default: ;
            endcase
        end
        if (!reset_n) m_q <= 8'h00;
        else          m_q <= q_next(in, m_q, m_sb12);
    end

    // Single compare process: literal expectations when posted, model otherwise
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        chk_en = 1'b0;
    logic        lit_valid = 1'b0;
    logic        lit_rb = 1'b0;
    logic [8:0]  lit_mask = 9'h000;
    logic [31:0] lit_exp = 32'h0;
    string       lit_name = "";

    always @(negedge clock) begin
        logic [31:0] act;
        logic [8:0]  mexp;
        if (lit_valid) begin
            act = lit_rb ? rdata : {23'h0, out & lit_mask};
            n_cmp = n_cmp + 1;
            if (act !== lit_exp) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got 0x%0h expected 0x%0h", lit_name, act, lit_exp);
            end
        end else if (chk_en) begin
            mexp = model_out(in);
            n_cmp = n_cmp + 1;
            if (out !== mexp) begin
                n_fail = n_fail + 1;
                $display("FAIL model_out t=%0t in=0x%0h: got 0x%0h expected 0x%0h", $time, in, out, mexp);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic lit_check(input string name, input logic rb, input logic [8:0] mask, input logic [31:0] exp);
        lit_name = name; lit_rb = rb; lit_mask = mask; lit_exp = exp; lit_valid = 1'b1;
        @(negedge clock);
        #1;
        lit_valid = 1'b0;
    endtask

    initial begin
        lit_check("powerup_out", 1'b0, 9'h1FF, 32'h0);
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        lit_check("reset_out", 1'b0, 9'h1FF, 32'h0);

        // Mux tree
        cfg_write(4'd6, 32'h000000CA);
        cfg_write(4'd7, 32'h0);
        cfg_write(4'd13, 32'h1);
        cfg_write(4'd14, 32'h1);
        in = 12'h055; lit_check("mux_sel0", 1'b0, 9'h1FF, 32'h1);
        in = 12'h155; lit_check("mux_sel1", 1'b0, 9'h1FF, 32'h0);
        in = 12'h555; lit_check("mux_sel5", 1'b0, 9'h1FF, 32'h0);
        in = 12'h37D; lit_check("mux_sel3", 1'b0, 9'h1FF, 32'h1);

        // Adder: XOR propagate/sum, majority carry
        cfg_write(4'd0, 32'h6);  cfg_write(4'd1, 32'h0);
        cfg_write(4'd2, 32'h6);  cfg_write(4'd3, 32'h0);
        cfg_write(4'd4, 32'hE8); cfg_write(4'd5, 32'h0);
        cfg_write(4'd12, 32'h1);
        cfg_write(4'd14, 32'h0);
        in = 12'h017; lit_check("add_3_1_1", 1'b0, 9'h1FF, 32'h5);
        in = 12'h00F; lit_check("add_3_3_0", 1'b0, 9'h1FF, 32'h6);

        // Shift register
        cfg_write(4'd8, 32'hCA);  cfg_write(4'd9, 32'h1);
        cfg_write(4'd10, 32'h2);  cfg_write(4'd11, 32'h0);
        cfg_write(4'd14, 32'h2);
        in = 12'h1A5; tick();
        lit_check("shift_load", 1'b0, 9'h0FF, 32'hA5);
        in = 12'hC00; tick();
        lit_check("shift_left", 1'b0, 9'h1FF, 32'h14B);
        in = 12'hE00; tick();
        lit_check("shift_right", 1'b0, 9'h1FF, 32'h1A5);
        reset_n = 1'b0; tick();
        reset_n = 1'b1; in = 12'h000;
        lit_check("reset_wins", 1'b0, 9'h1FF, 32'h0);
        in = 12'h13C; tick();
        in = 12'h000;
        lit_check("reload", 1'b0, 9'h1FF, 32'h3C);
        cfg_write(4'd15, 32'hFFFFFFFF);
        lit_check("addr15_ignored", 1'b0, 9'h1FF, 32'h3C);
`ifdef ADD_MUX_SHIFT_CFG_READBACK_EN
        cfg_addr = 4'd6; lit_check("readback_6", 1'b1, 9'h000, 32'hCA);
        cfg_addr = 4'd9; lit_check("readback_9", 1'b1, 9'h000, 32'h1);
`endif

        // Randomized run against the model
        reset_n = 1'b0; tick();
        reset_n = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_addr = 4'(12 + $urandom_range(0, 3));
            cfg_data = $urandom;
            reset_n  = ($urandom_range(0, 19) != 0);
            in       = 12'($urandom);
            tick();
        end
        cfg_we = 1'b0;
        reset_n = 1'b1;
        tick();
        chk_en = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/add_multiplex_shift.md
# add_multiplex_shift

Small configurable logic fabric: an array of LUT5 cells with fixed local routing and switch-box output selection. Loaded with the appropriate configuration words, it acts as a 2-bit adder, an 8:1 multiplexer or an 8-bit shift register, driven from 12 input pins onto 9 output pins. It is the top of the fabric and is configured through a word-write port.

## Interface
- No parameters.
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- in  in  12  fabric input pins
- out  out  9  fabric output pins
- cfg_we  in  1  configuration word write strobe
- cfg_addr  in  4  configuration word index, 0..14
- cfg_data  in  32  configuration word

## Operation
- Cell:
  - 32-bit LUT plus mode bit; 5 inputs a[4:0], unused inputs tied 0.
  - comb = LUT[a]; a flop captures comb every clock.
  - Output is the flop when mode=1, comb when mode=0.
- Configuration words are broadcast to every cell of a type, bit 0 only for mode words:
  - 0/1: ADD0 LUT/mode
  - 2/3: ADD1 LUT/mode
  - 4/5: ADDC LUT/mode
  - 6/7: MUX LUT/mode
  - 8/9: MUXS LUT/mode
  - 10/11: REGC LUT/mode
  - 12: SB0[15:0]
  - 13: SB1 and SB2[15:0]
  - 14: SB3[15:0]
  - Writes to cfg_addr 15 are ignored.
- Adder group, bits i=0,1:
  - a=in[1:0], b=in[3:2], c0=in[4].
  - ADD1_i(a_i,b_i) gives p_i.
  - ADDC_i(c_i,b_i,a_i) gives c_{i+1}.
  - ADD0_i(c_i,p_i) gives s_i.
- Mux group: 7 MUX cells in a tree.
  - Each cell has inputs {s,d1,d0} at a[2:0].
  - Level 1 pairs in[1:0], in[3:2], in[5:4], in[7:6] with s=in[8].
  - Level 2 uses s=in[9]; root uses s=in[10].
- Shift group, bits k=0..7, each a small 2:1 MUX cell tree:
  - MUX_Rk_1 picks hold(q_k)/load(in[k]) by in[8].
  - MUX_Rk_2 picks q_{k-1}/q_{k+1} by in[9].
  - MUXS_Rk picks between the two by in[10] and must be configured mode=1; it holds q_k.
  - Edge neighbours: q_{-1}=REGC_1(in[11]), q_8=REGC_2(in[11]).
- Switch boxes:
  - SB0[0] enables adder input routing; when 0, adder inputs read 0.
  - SB1/SB2[0] enables mux-tree and shift-tree select routing.
  - SB3[1:0] selects the output source:
    - 0: adder, out[1:0]=s, out[2]=c2, rest 0
    - 1: mux, out[0]=root, rest 0
    - 2: shift, out[7:0]=q, out[8]=REGC_2
    - 3: all 0
- Reset:
  - Reset clears all cell flops.
  - Configuration storage powers up 0 and is not affected by reset_n.
  - After power-up, out=0.

## Timing
- Combinational paths (mode=0 cells, switch boxes, output select) have zero latency from in to out.
- Registered cells update on the rising clock edge.
- reset_n=0 sampled at an edge zeroes every flop; it wins over a shift or load in the same cycle.
- A cfg_we write is stored on the clock edge and affects out from that edge onward.
- A write coinciding with reset is still stored.
- Reconfiguring mid-operation does not clear flops.

## Configuration
- ADD_MUX_SHIFT_CFG_READBACK_EN:
  - Defined: adds output cfg_rdata[31:0], combinationally returning the stored word at cfg_addr (mode words zero-extended, SB words zero-extended).
  - Undefined: no readback port, and storage is write-only.

## Test plan
- Mux, words 6=0x000000CA, 7=0, SB1/SB2=1, SB3=1:
  - in[7:0]=0x55, in[10:8]=000 -> out[0]=1
  - in[10:8]=001 -> out[0]=0
  - in[10:8]=101 -> out[0]=0
  - in[7:0]=0x7D, in[10:8]=011 -> out[0]=1
- Adder (p=XOR, carry=MAJ, sum=XOR LUTs), SB0=1, SB3=0: a=3, b=1, c0=1 -> out[2:0]=101.
- Shift, SB3=2, load LUT configs, MUXS mode=1:
  - Load 0xA5 -> out[7:0]=0xA5 after one edge.
  - Shift-left with in[11]=1 -> out[7:0]=0x4B next edge.
- Reset: reset_n=0 for one edge during shift -> out[7:0]=0x00; configuration retained, so a reload works immediately.
- A write to cfg_addr 15 leaves all outputs unchanged. With ADD_MUX_SHIFT_CFG_READBACK_EN defined, cfg_rdata at addr 6 reads 0x000000CA.
